imem_fetch_aligner: RTL and testbench

//  Parametrised instruction memory plus fetch aligner for the RV32IC core: replaces the flat

---
 rtl/imem_fetch_aligner_pkg.sv | 21 ++
 rtl/hw_fetch_queue.sv | 69 ++++++
 rtl/imem_fetch_aligner.sv | 126 ++++++++++++
 tb/tb_imem_fetch_aligner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_aligner_pkg.sv
// Shared fetch types: halfword/instruction widths,
// queue push bundle and the compressed-opcode test.
package imem_fetch_aligner_pkg;

  localparam int HW_W = 16;
  localparam int INST_W = 32;
  localparam logic [1:0] OPC_FULL = 2'b11;

  typedef logic [HW_W-1:0] hw_t;

  typedef struct packed {
    logic [1:0] n;
    hw_t        hw0;
    hw_t        hw1;
  } hw_push_t;

  function automatic logic is_compressed(input hw_t hw);
    return hw[1:0] != OPC_FULL;
  endfunction

endpackage

// File: rtl/hw_fetch_queue.sv
// Circular halfword FIFO: push 0..2, pop 0..2 per cycle,
// flush, occupancy count and peek of the two head entries.
module hw_fetch_queue
  import imem_fetch_aligner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  hw_push_t      push,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] cnt,
  output hw_t           q0,
  output hw_t           q1
);

  localparam int PW = CW - 1;

  hw_t buf_q [DEPTH];
  hw_t buf_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next pointers, count and storage for this cycle's push/pop
  always_comb begin
    buf_d = buf_q;
    wr_ptr_d = wr_ptr_q + PW'(push.n);
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    cnt_d = cnt_q + CW'(push.n) - CW'(pop_n);
    if (push.n != 2'd0) begin
      buf_d[wr_ptr_q] = push.hw0;
    end
    if (push.n == 2'd2) begin
      buf_d[wr_ptr_q + PW'(1)] = push.hw1;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d = '0;
    end
  end

  // Pointer and count state; reset empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only read once counted
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign cnt = cnt_q;
  assign q0 = buf_q[rd_ptr_q];
  assign q1 = buf_q[rd_ptr_q + PW'(1)];

endmodule

// File: rtl/imem_fetch_aligner.sv
// Instruction memory with word fetch into a halfword queue;
// emits one whole RV32IC instruction per handshake.
module imem_fetch_aligner
  import imem_fetch_aligner_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int FQ_HW = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_compressed
);

  localparam int MEM_B = 2 ** ADDR_W;
  localparam int CW = $clog2(FQ_HW) + 1;

  logic [7:0] mem [MEM_B];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              drop_first_q, drop_first_d;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     free_slots;
  logic [CW-1:0]     need;
  hw_t               q0, q1;
  hw_push_t          push;
  logic [1:0]        pop_n;
  logic              issue;
  logic              head_c;
  logic              have_inst;
  logic [31:0]       word;
  logic              unused_pc0;

  assign unused_pc0 = redirect_pc[0];

  assign word = {
    mem[{fetch_pc_q[ADDR_W-1:2], 2'd3}],
    mem[{fetch_pc_q[ADDR_W-1:2], 2'd2}],
    mem[{fetch_pc_q[ADDR_W-1:2], 2'd1}],
    mem[{fetch_pc_q[ADDR_W-1:2], 2'd0}]
  };

  hw_fetch_queue #(
    .DEPTH (FQ_HW),
    .CW    (CW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop_n (pop_n),
    .cnt   (cnt),
    .q0    (q0),
    .q1    (q1)
  );

  // Decode the queue head into an instruction and its pop size
  always_comb begin
    head_c = is_compressed(q0);
    have_inst = head_c ? (cnt >= CW'(1)) : (cnt >= CW'(2));
    out_valid = have_inst && !rst && !redirect_valid;
    out_compressed = out_valid && head_c;
    out_instr = '0;
    pop_n = 2'd0;
    if (out_valid) begin
      out_instr = head_c ? {{(INST_W-HW_W){1'b0}}, q0} : {q1, q0};
    end
    if (out_valid && out_ready) begin
      pop_n = head_c ? 2'd1 : 2'd2;
    end
  end

  assign out_pc = head_pc_q;

  // Issue a word read only if room remains after this cycle's pop
  always_comb begin
    free_slots = CW'(FQ_HW) - cnt + CW'(pop_n);
    need = drop_first_q ? CW'(1) : CW'(2);
    issue = !rst && !redirect_valid && (free_slots >= need);
    push = '0;
    unique case (1'b1)
      issue && drop_first_q:
        push = '{n: 2'd1, hw0: word[31:16], hw1: '0};
      issue && !drop_first_q:
        push = '{n: 2'd2, hw0: word[15:0], hw1: word[31:16]};
      default: push = '0;
    endcase
  end

  // Fetch/head PC bookkeeping; a redirect restarts both
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d = head_pc_q + ADDR_W'({pop_n, 1'b0});
    drop_first_d = drop_first_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      head_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
      drop_first_d = redirect_pc[1];
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      drop_first_d = 1'b0;
    end
  end

  // PC registers with synchronous reset to the boot address
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
      head_pc_q <= {RESET_PC[ADDR_W-1:1], 1'b0};
      drop_first_q <= RESET_PC[1];
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q <= head_pc_d;
      drop_first_q <= drop_first_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_aligner.sv
// Directed bench for imem_fetch_aligner with a
// scoreboard queue checked by a handshake monitor.
module tb_imem_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [11:0] out_pc;
  logic        out_compressed;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int cyc;

  imem_fetch_aligner #(
    .ADDR_W   (12),
    .FQ_HW    (4),
    .RESET_PC (12'h000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic put16(input int a, input logic [15:0] v);
    dut.mem[12'(a)] = v[7:0];
    dut.mem[12'(a + 1)] = v[15:8];
  endtask

  task automatic put32(input int a, input logic [31:0] v);
    put16(a, v[15:0]);
    put16(a + 2, v[31:16]);
  endtask

  task automatic expect_i(input logic [11:0] pc,
                          input logic [31:0] instr,
                          input logic comp);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.comp = comp;
    sb.push_back(e);
  endtask

  // Raise ready until n handshakes complete; cycles used returned
  task automatic consume(input int n, output int c);
    int target;
    @(posedge clk); #1;
    target = hs_cnt + n;
    out_ready = 1'b1;
    c = 0;
    while (hs_cnt < target && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    chk("consume_done", 64'(hs_cnt), 64'(target));
  endtask

  task automatic do_redirect(input logic [11:0] pc,
                             input logic rdy);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = pc;
    out_ready = rdy;
    @(negedge clk);
    chk("redirect_cycle_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Monitor: every handshake pops one expected instruction
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected pc=%0h instr=%0h",
                 out_pc, out_instr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(mon_e.pc));
        chk("sb_instr", 64'(out_instr), 64'(mon_e.instr));
        chk("sb_comp", 64'(out_compressed), 64'(mon_e.comp));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) dut.mem[i] = 8'h00;
    put32(12'h000, 32'h00500093);
    put16(12'h004, 16'h4505);
    put32(12'h006, 32'h00500093);
    put32(12'h00A, 32'h00100113);
    put32(12'h00E, 32'h00200193);
    put32(12'h012, 32'h00300213);
    put32(12'h016, 32'h00400293);
    put32(12'h01A, 32'h00500313);
    put16(12'hFFC, 16'h4505);
    put16(12'hFFE, 16'h0001);

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_pc", 64'(out_pc), 0);
    chk("rst_instr", 64'(out_instr), 0);
    chk("rst_comp", 64'(out_compressed), 0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("boot_c1_valid", 64'(out_valid), 0);
    @(negedge clk);
    chk("boot_c2_valid", 64'(out_valid), 1);
    chk("boot_pc", 64'(out_pc), 0);
    chk("boot_instr", 64'(out_instr), 64'h00500093);
    chk("boot_comp", 64'(out_compressed), 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold",
          64'({out_valid, out_pc, out_instr, out_compressed}),
          64'({1'b1, 12'h000, 32'h00500093, 1'b0}));
    end
    chk("stall_count", 64'(dut.u_queue.cnt_q), 4);
    chk("stall_fetch_pc", 64'(dut.fetch_pc_q), 64'h008);

    expect_i(12'h000, 32'h00500093, 1'b0);
    expect_i(12'h004, 32'h00004505, 1'b1);
    expect_i(12'h006, 32'h00500093, 1'b0);
    expect_i(12'h00A, 32'h00100113, 1'b0);
    expect_i(12'h00E, 32'h00200193, 1'b0);
    expect_i(12'h012, 32'h00300213, 1'b0);
    expect_i(12'h016, 32'h00400293, 1'b0);
    consume(7, cyc);
    chk("stream_gapless", 64'(cyc), 7);

    do_redirect(12'h00A, 1'b0);
    @(negedge clk);
    chk("rdA_n1_valid", 64'(out_valid), 0);
    @(negedge clk);
    chk("rdA_n2_valid", 64'(out_valid), 0);
    @(negedge clk);
    chk("rdA_n3_valid", 64'(out_valid), 1);
    chk("rdA_n3_pc", 64'(out_pc), 64'h00A);
    chk("rdA_n3_instr", 64'(out_instr), 64'h00100113);
    expect_i(12'h00A, 32'h00100113, 1'b0);
    consume(1, cyc);

    do_redirect(12'h00C, 1'b0);
    @(negedge clk);
    chk("rdC_n1_valid", 64'(out_valid), 0);
    @(negedge clk);
    chk("rdC_n2_valid", 64'(out_valid), 1);
    chk("rdC_n2_pc", 64'(out_pc), 64'h00C);
    chk("rdC_n2_instr", 64'(out_instr), 64'h00000010);
    chk("rdC_n2_comp", 64'(out_compressed), 1);

    expect_i(12'h004, 32'h00004505, 1'b1);
    expect_i(12'h006, 32'h00500093, 1'b0);
    do_redirect(12'h004, 1'b1);
    consume(2, cyc);

    expect_i(12'hFFC, 32'h00004505, 1'b1);
    expect_i(12'hFFE, 32'h00000001, 1'b1);
    expect_i(12'h000, 32'h00500093, 1'b0);
    do_redirect(12'hFFC, 1'b1);
    consume(3, cyc);

    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 0);
    chk("post_rst_pc", 64'(out_pc), 0);
    chk("post_rst_instr", 64'(out_instr), 0);
    chk("post_rst_comp", 64'(out_compressed), 0);
    expect_i(12'h000, 32'h00500093, 1'b0);
    consume(1, cyc);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
